// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter slice.
//   - state_t : sequencer states (IDLE, ACCESS, RESP)
//   - NPORT   : number of requester ports
//   - cmd_t   : command latched at grant time (port index, write flag,
//               address, write data); address/data fields are CMD_AW/CMD_DW
//               wide, so the arbiter's AW and DW must not exceed them.
package dmem_arb_pkg;

  localparam int NPORT  = 2;
  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              idx;
    logic              we;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin picker. The pointer register lives in
//   the caller; this block only decides who wins this cycle.
//   Ports:
//     req [1:0] in  per-port request
//     rr        in  port that wins when both request
//     gnt [1:0] out one-hot grant (zero when nobody requests)
//     idx       out index of the granted port (0 when nobody requests)
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic             rr,
  output logic [NPORT-1:0] gnt,
  output logic             idx
);

  // A lone requester wins outright; a tie is broken by the pointer.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = rr ? 2'b10 : 2'b01;
    end
  end

  assign idx = gnt[1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one level-sensitive data memory between the CPU load/store port
//   (port 0) and a debug/loader port (port 1). Every granted transaction runs
//   IDLE -> ACCESS -> RESP with registered memory strobes, so the memory only
//   ever sees stable, mutually exclusive read/write commands.
//
//   Optional feature: define DMEM_ARB_RANGE_CHK_EN to reject addresses
//   >= DEPTH (no memory strobe, rsp_err=1 in RESP). Without it, addresses
//   pass straight through and rsp_err stays 0.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     req, we [1:0]       per-port request (held until gnt) and write enable
//     addr0/1, wdata0/1   per-port word index and write data
//     gnt [1:0]           one-hot grant pulse, combinational in IDLE
//     rsp_valid [1:0]     one-hot response pulse, two cycles after gnt
//     rsp_err             qualifies rsp_valid: out-of-range address
//     rdata               read data, held between reads
//     mem_addr/mem_wdata  command address/data to the memory
//     mem_write/mem_read  registered memory strobes, high only in ACCESS
//     mem_rdata           combinational read data from the memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] we,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [DW-1:0]    wdata0,
  input  logic [DW-1:0]    wdata1,
  output logic [NPORT-1:0] gnt,
  output logic [NPORT-1:0] rsp_valid,
  output logic             rsp_err,
  output logic [DW-1:0]    rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_write,
  output logic             mem_read,
  input  logic [DW-1:0]    mem_rdata
);

  state_t           state;
  logic             rr;
  cmd_t             cmd_q;
  logic [NPORT-1:0] arb_gnt;
  logic             arb_idx;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic             sel_ok;
  logic             cmd_ok;

  rr_arb2 u_rr_arb2 (
    .req (req),
    .rr  (rr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign sel_addr  = arb_idx ? addr1 : addr0;
  assign sel_wdata = arb_idx ? wdata1 : wdata0;

`ifdef DMEM_ARB_RANGE_CHK_EN
  assign sel_ok = (sel_addr < AW'(DEPTH));
  assign cmd_ok = (cmd_q.addr < CMD_AW'(DEPTH));
`else
  assign sel_ok = 1'b1;
  assign cmd_ok = 1'b1;
`endif

  // Grant is only offered in IDLE; gating with rst_n keeps it at zero while
  // reset is held, since no edge taken in reset can accept a request.
  assign gnt = (state == IDLE && rst_n) ? arb_gnt : '0;

  // The memory sees the latched command, never the live requester inputs.
  assign mem_addr  = AW'(cmd_q.addr);
  assign mem_wdata = DW'(cmd_q.wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      cmd_q     <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
          if (|req) begin
            cmd_q.idx   <= arb_idx;
            cmd_q.we    <= we[arb_idx];
            cmd_q.addr  <= CMD_AW'(sel_addr);
            cmd_q.wdata <= CMD_DW'(sel_wdata);
            // A rejected address simply never raises a strobe.
            mem_write   <= we[arb_idx] & sel_ok;
            mem_read    <= ~we[arb_idx] & sel_ok;
            rr          <= ~arb_idx;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          // mem_read is high exactly for an accepted read, so it doubles as
          // the capture enable.
          if (mem_read) begin
            rdata <= mem_rdata;
          end
          rsp_valid <= cmd_q.idx ? 2'b10 : 2'b01;
          rsp_err   <= ~cmd_ok;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A small array stands in for the
//   data memory; a separate reference memory plus a tie-break preference
//   variable predict grants, strobes and responses.
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt;
  logic [1:0]    rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write, mem_read;
  logic [DW-1:0] mem_rdata;
  logic          preload;

  logic [31:0] phys_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          prefer;
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 0) ? 32'd5 : 32'h100 + 32'(i);
  endfunction

  function automatic logic [1:0] oh(int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [31:0] rand_addr();
    return RANGE_CHK ? $urandom_range(19, 0) : $urandom_range(15, 0);
  endfunction

  // Memory stand-in: combinational read, write on the rising edge.
  assign mem_rdata = (mem_addr < DEPTH) ? phys_mem[mem_addr[3:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) phys_mem[i] <= init_word(i);
    end else if (mem_write && mem_addr < DEPTH) begin
      phys_mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; preload = 1'b1; req = 2'b11; we = 2'b00;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    prefer = 0; last_rdata = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_ctl got gnt=%b rsp=%b err=%b want 00 00 0", gnt, rsp_valid, rsp_err); end
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_strobe got wr=%b rd=%b want 0 0", mem_write, mem_read); end
    checks++;
    if (rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0)
      begin errors++; $display("[TB] FAIL reset_data got rdata=%h addr=%h wdata=%h want 0", rdata, mem_addr, mem_wdata); end
    req = 2'b00; preload = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    req = 2'b01; we = 2'b01; addr0 = 3; wdata0 = 32'h1234;
    #1;
    checks++;
    if (gnt !== oh(0)) begin errors++; $display("[TB] FAIL wr_gnt got %b want %b", gnt, oh(0)); end
    prefer = 1;
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 3 || mem_wdata !== 32'h1234)
      begin errors++; $display("[TB] FAIL wr_access got wr=%b rd=%b addr=%0d data=%h want 1 0 3 1234", mem_write, mem_read, mem_addr, mem_wdata); end
    @(negedge clk);
    ref_mem[3] = 32'h1234;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || mem_write !== 1'b0)
      begin errors++; $display("[TB] FAIL wr_resp got rsp=%b err=%b wr=%b want 01 0 0", rsp_valid, rsp_err, mem_write); end
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr0 = 3;
    #1;
    checks++;
    if (gnt !== oh(0)) begin errors++; $display("[TB] FAIL rd_gnt got %b want %b", gnt, oh(0)); end
    prefer = 1;
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 3)
      begin errors++; $display("[TB] FAIL rd_access got rd=%b wr=%b addr=%0d want 1 0 3", mem_read, mem_write, mem_addr); end
    @(negedge clk);
    last_rdata = ref_mem[3];
    checks++;
    if (rsp_valid !== 2'b01 || rdata !== last_rdata)
      begin errors++; $display("[TB] FAIL rd_resp got rsp=%b rdata=%h want 01 %h", rsp_valid, rdata, last_rdata); end
    @(negedge clk);
  endtask

  task automatic test_preload_read();
    req = 2'b10; we = 2'b00; addr1 = 0;
    #1;
    checks++;
    if (gnt !== oh(1)) begin errors++; $display("[TB] FAIL p1_gnt got %b want %b", gnt, oh(1)); end
    prefer = 0;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    last_rdata = ref_mem[0];
    checks++;
    if (rsp_valid !== 2'b10 || rdata !== last_rdata || rdata !== 32'd5)
      begin errors++; $display("[TB] FAIL p1_resp got rsp=%b rdata=%h want 10 %h", rsp_valid, rdata, last_rdata); end
    @(negedge clk);
  endtask

`ifdef DMEM_ARB_RANGE_CHK_EN
  task automatic test_range();
    req = 2'b01; we = 2'b01; addr0 = 16; wdata0 = 32'hBAD0_0001;
    #1;
    prefer = 1;
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0)
      begin errors++; $display("[TB] FAIL range_strobe got wr=%b rd=%b want 0 0", mem_write, mem_read); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rdata !== last_rdata)
      begin errors++; $display("[TB] FAIL range_resp got rsp=%b err=%b rdata=%h want 01 1 %h", rsp_valid, rsp_err, rdata, last_rdata); end
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr0 = 0;
    #1;
    prefer = 1;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    last_rdata = ref_mem[0];
    checks++;
    if (rsp_err !== 1'b0 || rdata !== last_rdata)
      begin errors++; $display("[TB] FAIL range_after got err=%b rdata=%h want 0 %h", rsp_err, rdata, last_rdata); end
    @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back();
    logic [1:0] last_g;
    rst_n = 1'b0;
    @(negedge clk);
    prefer = 0; last_rdata = 0;
    req = 2'b11; we = 2'b00; addr0 = 7; addr1 = 9;
    rst_n = 1'b1;
    last_g = 2'b00;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++;
      if (gnt !== ((k % 3 == 0) ? oh(prefer) : 2'b00))
        begin errors++; $display("[TB] FAIL b2b_gnt k=%0d got %b want %b", k, gnt, (k % 3 == 0) ? oh(prefer) : 2'b00); end
      checks++;
      if (mem_write === 1'b1 && mem_read === 1'b1)
        begin errors++; $display("[TB] FAIL b2b_excl k=%0d got wr=1 rd=1 want not both", k); end
      if (k % 3 == 0) begin
        last_g = oh(prefer);
        prefer = 1 - prefer;
      end
      if (k % 3 == 2) begin
        last_rdata = ref_mem[last_g[1] ? 9 : 7];
        checks++;
        if (rsp_valid !== last_g || rdata !== last_rdata)
          begin errors++; $display("[TB] FAIL b2b_resp k=%0d got rsp=%b rdata=%h want %b %h", k, rsp_valid, rdata, last_g, last_rdata); end
      end
      @(negedge clk);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    req = 2'b01; we = 2'b00; addr0 = 2;
    #1;
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre got rd=%b want 1", mem_read); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0)
      begin errors++; $display("[TB] FAIL mid_drop got wr=%b rd=%b want 0 0", mem_write, mem_read); end
    req = 2'b11;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL mid_norsp got %b want 00", rsp_valid); end
    rst_n = 1'b1; prefer = 0; last_rdata = 0;
    #1;
    checks++;
    if (gnt !== 2'b01 || rsp_valid !== 2'b00)
      begin errors++; $display("[TB] FAIL mid_tie got gnt=%b rsp=%b want 01 00", gnt, rsp_valid); end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 2'b00 || mem_read !== 1'b0 || mem_write !== 1'b0)
      begin errors++; $display("[TB] FAIL mid_idle got rsp=%b rd=%b wr=%b want 00 0 0", rsp_valid, mem_read, mem_write); end
  endtask

  task automatic test_random();
    logic        pv [2];
    logic        pwe [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    int          w;
    logic        ok;
    for (int p = 0; p < 2; p++) begin pv[p] = 0; pwe[p] = 0; pa[p] = 0; pd[p] = 0; end
    for (int t = 0; t < 80; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(1, 0) == 1) begin
          pv[p] = 1; pwe[p] = 1'($urandom_range(1, 0)); pa[p] = rand_addr(); pd[p] = $urandom();
        end
      end
      req = {pv[1], pv[0]}; we = {pwe[1], pwe[0]};
      addr0 = pa[0]; addr1 = pa[1]; wdata0 = pd[0]; wdata1 = pd[1];
      #1;
      if (!pv[0] && !pv[1]) begin
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL rand_idle t=%0d got gnt=%b want 00", t, gnt); end
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || rsp_valid !== 2'b00)
          begin errors++; $display("[TB] FAIL rand_stay t=%0d got rd=%b wr=%b rsp=%b want 0 0 00", t, mem_read, mem_write, rsp_valid); end
        continue;
      end
      w = (pv[0] && pv[1]) ? prefer : (pv[1] ? 1 : 0);
      checks++;
      if (gnt !== oh(w)) begin errors++; $display("[TB] FAIL rand_gnt t=%0d got %b want %b", t, gnt, oh(w)); end
      prefer = 1 - w;
      ok = !RANGE_CHK || (pa[w] < DEPTH);
      @(negedge clk);
      checks++;
      if (mem_write !== (pwe[w] & ok) || mem_read !== (~pwe[w] & ok) || mem_addr !== pa[w] || gnt !== 2'b00)
        begin errors++; $display("[TB] FAIL rand_access t=%0d got wr=%b rd=%b addr=%0d gnt=%b want %b %b %0d 00", t, mem_write, mem_read, mem_addr, gnt, pwe[w] & ok, ~pwe[w] & ok, pa[w]); end
      pv[w] = 0;
      // Scribble on the winner's live inputs; the latched command must hold.
      if (w == 0) begin req[0] = 1'($urandom_range(1, 0)); addr0 = $urandom(); wdata0 = $urandom(); end
      else begin req[1] = 1'($urandom_range(1, 0)); addr1 = $urandom(); wdata1 = $urandom(); end
      @(negedge clk);
      if (ok && !pwe[w]) last_rdata = ref_mem[pa[w][3:0]];
      if (ok && pwe[w]) ref_mem[pa[w][3:0]] = pd[w];
      checks++;
      if (rsp_valid !== oh(w) || rsp_err !== !ok || rdata !== last_rdata || mem_read !== 1'b0 || mem_write !== 1'b0)
        begin errors++; $display("[TB] FAIL rand_resp t=%0d got rsp=%b err=%b rdata=%h want %b %b %h", t, rsp_valid, rsp_err, rdata, oh(w), !ok, last_rdata); end
      @(negedge clk);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    preload = 1'b0;
    test_reset();
    test_write_read();
    test_preload_read();
`ifdef DMEM_ARB_RANGE_CHK_EN
    test_range();
`endif
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-cycle core's data memory. It shares one `data_memory` instance between the CPU load/store port (port 0) and a debug/loader port (port 1). Each granted transaction runs through a fixed three-state sequence with registered memory commands, so the level-sensitive memory only sees stable, mutually exclusive read/write strobes. Reads and writes both return a one-cycle response.

## Interface
- `AW`, 32: address width on requester and memory ports.
- `DW`, 32: data width.
- `DEPTH`, 16: number of memory words; a word index is valid when `addr < DEPTH`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req[1:0]`  in  2  per-port request; held high until `gnt` for that port.
- `we[1:0]`  in  2  per-port write enable; 0 means read.
- `addr0`, `addr1`  in  AW  per-port word index.
- `wdata0`, `wdata1`  in  DW  per-port write data.
- `gnt[1:0]`  out  2  one-hot grant pulse; the request is sampled at this edge.
- `rsp_valid[1:0]`  out  2  one-hot, one-cycle response pulse.
- `rsp_err`  out  1  qualifies `rsp_valid`; set for an out-of-range address.
- `rdata`  out  DW  read data, valid with `rsp_valid` on reads; holds its value otherwise.
- `mem_addr`  out  AW  to memory `addr`.
- `mem_wdata`  out  DW  to memory `write_data`.
- `mem_write`, `mem_read`  out  1  to memory strobes; never both high.
- `mem_rdata`  in  DW  from memory `read_data`, combinational.

## Operation
- FSM states and transitions:
  - IDLE goes to ACCESS when any `req` is high.
  - ACCESS goes to RESP unconditionally.
  - RESP goes to IDLE unconditionally.
- IDLE:
  - `gnt` is combinational from `req` and the round-robin pointer `rr`.
  - At the edge, the winner's index, `we`, `addr` and `wdata` are latched into command registers.
  - `rr` is then set to the other port.
- Arbitration:
  - If only one port requests, that port wins.
  - If both request, port `rr` wins.
  - `rr` resets to 0, so after reset port 0 wins a tie.
- ACCESS:
  - `mem_addr` and `mem_wdata` are driven from the command registers.
  - `mem_write` is high for a write, `mem_read` for a read. Both are registered outputs, high only during ACCESS.
  - At the end of ACCESS, `mem_rdata` is captured into `rdata` for reads.
- RESP:
  - `rsp_valid[idx]` is high for one cycle.
  - The memory strobes are low.
- A requester may keep `req` high after `gnt` to queue its next transaction. It becomes eligible again at the next IDLE.
- No pending request in IDLE means the FSM stays in IDLE and all outputs stay at their idle values.

## Timing
- Reset values:
  - `gnt`, `rsp_valid`, `rsp_err`, `mem_write`, `mem_read` = 0.
  - `rdata`, `mem_addr`, `mem_wdata` = 0.
  - `rr` = 0, state = IDLE.
- Latency: `gnt` in cycle N, memory strobe in N+1, `rsp_valid` in N+2. Peak throughput is one transaction per 3 cycles.
- Write visibility: a read granted after a write's `rsp_valid` returns the new data.
- Reset asserted mid-transaction:
  - The memory strobes drop immediately (asynchronously).
  - The transaction is discarded and no `rsp_valid` is issued.
  - A write aborted after its ACCESS edge may already have been performed.
- A `req` that drops before `gnt` is legal and is simply not served.
- `req` changing during ACCESS or RESP has no effect.

## Configuration
- `DMEM_ARB_RANGE_CHK_EN` defined:
  - A command with `addr >= DEPTH` suppresses both memory strobes in ACCESS. Memory is untouched.
  - RESP asserts `rsp_err`=1 with `rdata` unchanged. Sequence and timing are unchanged.
- Undefined:
  - No check is made. `rsp_err` is tied 0.
  - The address is passed through unmodified.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the `NPORT=2` constant;
  - the command struct (`idx`, `we`, `addr`, `wdata`).
- Sub-module `rr_arb2`: combinational two-way round-robin picker. Inputs `req[1:0]` and `rr`; outputs a one-hot `gnt` and the index. The pointer register stays in `dmem_arbiter`.

## Test plan
- Reset then port 0 write 0x1234 to addr 3 → `gnt`=01 in cycle N; `mem_write`=1 with `mem_addr`=3 in N+1; `rsp_valid`=01 in N+2. A subsequent read of addr 3 returns `rdata`=0x1234.
- Both ports request continuously from reset → grants alternate 01, 10, 01, 10, with `gnt` pulses 3 cycles apart. `mem_read`&`mem_write` is never 1.
- Port 1 reads addr 0 on a preloaded memory (word 0 = 5) → `rsp_valid`=10 and `rdata`=5 two cycles after `gnt`.
- With `DMEM_ARB_RANGE_CHK_EN`, a write to addr 16 → no strobe in ACCESS, then `rsp_err`=1. A later read of addr 0 is unaffected.
- `rst_n` pulsed low during ACCESS of a read → strobes are 0 in the same cycle, no `rsp_valid`. After release the state is IDLE and port 0 wins a tie.
